// File: rtl/piso_arbiter_if.sv
// Handshake bundle between the byte producers, the piso_arbiter and the serializer write port.
// slave is the arbiter's view; master is the view of whatever drives the producers and the serializer.
interface piso_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH*DW-1:0] req_data_i;
    logic [NUM_CH-1:0]    req_valid_i;
    logic [NUM_CH-1:0]    req_ready_o;
    logic [DW-1:0]        data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [CW-1:0]        ch_id_o;
    logic [NUM_CH-1:0]    grant_o;
    logic                 busy_o;

    modport slave (
        input  req_data_i, req_valid_i, ready_i,
        output req_ready_o, data_o, valid_o, ch_id_o, grant_o, busy_o
    );

    modport master (
        output req_data_i, req_valid_i, ready_i,
        input  req_ready_o, data_o, valid_o, ch_id_o, grant_o, busy_o
    );
endinterface

// File: rtl/piso_arbiter.sv
// Round-robin burst arbiter feeding one byte serializer from NUM_CH valid/ready producers.
// Define PISO_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module piso_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8,
    parameter int BURST  = 4
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    piso_arbiter_if.slave  bus
);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t            state;
    logic [NUM_CH-1:0] grant_q;
    logic [CW-1:0]     cur_ch;
    logic [3:0]        count;
    logic [DW-1:0]     data_q;
    logic              valid_q;
    logic [CW-1:0]     ch_id_q;
`ifndef PISO_ARB_FIXED_PRIO_EN
    logic [CW-1:0]     ptr;
`endif

    logic          in_grant;
    logic          out_free;
    logic          cur_valid;
    logic          accept;
    logic [DW-1:0] cur_data;
    logic          sel_found;
    logic [CW-1:0] sel_idx;
    int            cand;

    assign in_grant  = (state == S_GRANT);
    assign out_free  = !valid_q || bus.ready_i;
    assign cur_valid = bus.req_valid_i[cur_ch];
    assign accept    = in_grant && cur_valid && out_free;

    // grant_q is already one-hot on g, so ready never depends on req_valid_i
    assign bus.req_ready_o = (in_grant && out_free) ? grant_q : '0;
    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.ch_id_o     = ch_id_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = in_grant || valid_q;

    always_comb begin
        cur_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CW'(k) == cur_ch) begin
                cur_data = bus.req_data_i[k*DW +: DW];
            end
        end
    end

    // Search order starts just past the last winner and wraps without needing a power-of-2 NUM_CH
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef PISO_ARB_FIXED_PRIO_EN
            cand = i;
`else
            cand = int'(ptr) + 1 + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
`endif
            if (!sel_found && bus.req_valid_i[CW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            grant_q <= '0;
            cur_ch  <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_id_q <= '0;
`ifndef PISO_ARB_FIXED_PRIO_EN
            ptr     <= CW'(NUM_CH - 1);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        grant_q <= NUM_CH'(1) << sel_idx;
                        cur_ch  <= sel_idx;
                        count   <= '0;
                        state   <= S_GRANT;
`ifndef PISO_ARB_FIXED_PRIO_EN
                        ptr     <= sel_idx;
`endif
                    end else begin
                        grant_q <= '0;
                    end
                end
                S_GRANT: begin
                    if (!cur_valid) begin
                        grant_q <= '0;
                        state   <= S_IDLE;
                    end else if (accept) begin
                        if (count == 4'(BURST - 1)) begin
                            count   <= '0;
                            grant_q <= '0;
                            state   <= S_IDLE;
                        end else begin
                            count <= count + 4'd1;
                        end
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
            endcase

            // A new byte may overwrite one being consumed in the same cycle
            if (accept) begin
                data_q  <= cur_data;
                ch_id_q <= cur_ch;
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_piso_arbiter.sv
// Self-checking bench for piso_arbiter: vector table, scoreboard and multi-cycle corner sequences.
// Also exercises a NUM_CH=3 instance for pointer wrap; honours PISO_ARB_FIXED_PRIO_EN.
module tb_piso_arbiter;
    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic       evalid;
        logic [7:0] edata;
        logic [1:0] ech;
        logic [3:0] egrant;
        logic [3:0] erdy;
        logic       ebusy;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    piso_arbiter_if #(.NUM_CH(4), .DW(8)) bus ();
    piso_arbiter_if #(.NUM_CH(3), .DW(8)) busB ();

    piso_arbiter #(.NUM_CH(4), .DW(8), .BURST(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    piso_arbiter #(.NUM_CH(3), .DW(8), .BURST(4)) dutB (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (busB)
    );

    int         tests = 0;
    int         fails = 0;
    sb_t        sbq[$];
    vec_t       tbl[10];
    logic [7:0] cnt[4];
    logic [7:0] lim[4];
    logic [3:0] prod_en;
    logic [3:0] hs;
    bit         auto_prod;
    bit         mon_en;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int ch, input int data);
        sb_t e;
        e.ch   = 2'(ch);
        e.data = 8'(data);
        sbq.push_back(e);
    endtask

    task automatic driveProd();
        for (int k = 0; k < 4; k++) begin
            bus.req_data_i[k*8 +: 8] = 8'(k * 16) + cnt[k];
            bus.req_valid_i[k]       = prod_en[k] && (cnt[k] < lim[k]);
        end
    endtask

    // Monitor at the falling edge, then advance one cycle and let producers step
    task automatic applyStimulus();
        sb_t e;
        @(negedge clk);
        hs = bus.req_valid_i & bus.req_ready_o;
        if (mon_en && bus.valid_o && bus.ready_i) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL sb_unexpected: got %0h from ch %0d, expected nothing", bus.data_o, bus.ch_id_o);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_byte", {22'd0, bus.ch_id_o, bus.data_o}, {22'd0, e.ch, e.data});
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) cnt[k] = cnt[k] + 8'd1;
        end
        if (auto_prod) driveProd();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        auto_prod = 1'b0;
        mon_en    = 1'b0;
        sbq.delete();
        prod_en   = '0;
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 8'd0;
            lim[k] = 8'd255;
        end
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.ready_i      = 1'b1;
        busB.req_valid_i = '0;
        busB.req_data_i  = '0;
        busB.ready_i     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 2'd0, 4'h4, 4'h4, 1'b1};
        tbl[2] = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hA0, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[3] = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[4] = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA2, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[5] = '{1'b1, 8'hA4, 1'b1, 1'b1, 8'hA3, 2'd2, 4'h0, 4'h0, 1'b1};
        tbl[6] = '{1'b1, 8'hA4, 1'b1, 1'b0, 8'hA3, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[7] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA4, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[8] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 2'd2, 4'h4, 4'h4, 1'b1};
        tbl[9] = '{1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 2'd2, 4'h0, 4'h0, 1'b0};

        rst_n            = 1'b0;
        auto_prod        = 1'b0;
        mon_en           = 1'b0;
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.ready_i      = 1'b0;
        busB.req_valid_i = '0;
        busB.req_data_i  = '0;
        busB.ready_i     = 1'b0;
        #12;
        checkOutput("reset_a", {11'd0, bus.valid_o, bus.data_o, bus.ch_id_o, bus.grant_o, bus.req_ready_o, bus.busy_o}, 32'd0);
        checkOutput("reset_b", {14'd0, busB.valid_o, busB.data_o, busB.ch_id_o, busB.grant_o, busB.busy_o}, 32'd0);

        // Single producer on ch2: exact cycle-by-cycle outputs
        doReset();
        mon_en = 1'b1;
        for (int j = 0; j < 6; j++) pushExp(2, 8'hA0 + j);
        for (int i = 0; i < 10; i++) begin
            bus.req_valid_i = {1'b0, tbl[i].vld, 2'b00};
            bus.req_data_i  = {8'h00, tbl[i].din, 16'h0000};
            bus.ready_i     = tbl[i].rdy;
            #1;
            checkOutput($sformatf("vec%0d", i),
                        {12'd0, bus.valid_o, bus.data_o, bus.ch_id_o, bus.grant_o, bus.req_ready_o, bus.busy_o},
                        {12'd0, tbl[i].evalid, tbl[i].edata, tbl[i].ech, tbl[i].egrant, tbl[i].erdy, tbl[i].ebusy});
            applyStimulus();
        end
        checkOutput("single_drain", sbq.size(), 0);

        // Continuous contention on all four channels
        doReset();
        auto_prod = 1'b1;
        mon_en    = 1'b1;
        prod_en   = 4'hF;
        driveProd();
`ifdef PISO_ARB_FIXED_PRIO_EN
        for (int j = 0; j < 20; j++) pushExp(0, j);
`else
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) pushExp(c, c * 16 + j);
        end
        for (int j = 4; j < 8; j++) pushExp(0, j);
`endif
        for (int n = 0; n < 80 && sbq.size() != 0; n++) applyStimulus();
        checkOutput("contention_drain", sbq.size(), 0);

        // Three stalled cycles in the middle of a burst
        doReset();
        auto_prod = 1'b1;
        mon_en    = 1'b1;
        prod_en   = 4'b0001;
        driveProd();
        for (int j = 0; j < 8; j++) pushExp(0, j);
        for (int cyc = 0; cyc < 40 && (sbq.size() != 0 || cyc < 9); cyc++) begin
            bus.ready_i = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                checkOutput("stall_valid", {31'd0, bus.valid_o}, 32'd1);
                checkOutput("stall_data", {24'd0, bus.data_o}, 32'h01);
                checkOutput("stall_ready", {28'd0, bus.req_ready_o}, 32'd0);
            end
            if (cyc == 7) checkOutput("stall_grant_hold", {28'd0, bus.grant_o}, 32'h1);
            if (cyc == 8) checkOutput("stall_release", {28'd0, bus.grant_o}, 32'h0);
            applyStimulus();
        end
        checkOutput("stall_drain", sbq.size(), 0);

        // ch1 gives up after two bytes; ch3 takes over
        doReset();
        auto_prod = 1'b1;
        mon_en    = 1'b1;
        prod_en   = 4'b1010;
        lim[1]    = 8'd2;
        driveProd();
        pushExp(1, 8'h10);
        pushExp(1, 8'h11);
        for (int j = 0; j < 4; j++) pushExp(3, 8'h30 + j);
        for (int cyc = 0; cyc < 40 && (sbq.size() != 0 || cyc < 6); cyc++) begin
            #1;
            if (cyc == 3) checkOutput("early_grant_c3", {28'd0, bus.grant_o}, 32'b0010);
            if (cyc == 4) checkOutput("early_grant_c4", {28'd0, bus.grant_o}, 32'b0000);
            if (cyc == 5) checkOutput("early_grant_c5", {28'd0, bus.grant_o}, 32'b1000);
            applyStimulus();
        end
        checkOutput("early_drain", sbq.size(), 0);

        // NUM_CH=3 pointer wrap
        doReset();
        busB.req_valid_i = 3'b101;
        busB.req_data_i  = {8'hC2, 8'h00, 8'hC0};
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (cyc == 1) checkOutput("wrap_first", {29'd0, busB.grant_o}, 32'b001);
            if (cyc == 2) checkOutput("wrap_byte", {22'd0, busB.ch_id_o, busB.data_o}, {22'd0, 2'd0, 8'hC0});
`ifdef PISO_ARB_FIXED_PRIO_EN
            if (cyc == 6) checkOutput("wrap_second", {29'd0, busB.grant_o}, 32'b001);
`else
            if (cyc == 6) checkOutput("wrap_second", {29'd0, busB.grant_o}, 32'b100);
`endif
            applyStimulus();
        end

        // Asynchronous reset while a byte sits in the output stage
        doReset();
        auto_prod = 1'b1;
        prod_en   = 4'b0101;
        driveProd();
        repeat (3) applyStimulus();
        checkOutput("rst_pre_valid", {31'd0, bus.valid_o}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", {26'd0, bus.valid_o, bus.grant_o, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("rst_first_grant", {28'd0, bus.grant_o}, 32'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
